// File: rtl/ir_packet_transmitter.sv
// ir_packet_transmitter
//   Turns a SEND_PACKET request into one remote-control car IR packet:
//   Start, CarSelect, Right, Left, Backward and Forward bursts, each
//   followed by a gap. Bursts are modulated on a carrier whose half
//   period is HALF = CLK_FREQ/(2*CARRIER_FREQ) clocks.
//
//   Ports:
//     CLK          system clock
//     RESET        asynchronous reset, active low
//     COMMAND[3:0] [0]=Right [1]=Left [2]=Backward [3]=Forward
//     SEND_PACKET  packet request, rising edge triggered
//     IR_LED       modulated IR output (registered)
//     BUSY         high while a packet is in progress
//     PACKET_DONE  one-cycle pulse when the final gap completes
//
//   Optional build macro IR_PENDING_EN: a request arriving while busy is
//   remembered (with its COMMAND) and sent right after the current packet.
//   Without the macro such requests are dropped.
module ir_packet_transmitter #(
    parameter int unsigned CLK_FREQ       = 100000000,
    parameter int unsigned CARRIER_FREQ   = 36000,
    parameter int unsigned START_BURST    = 191,
    parameter int unsigned GAP            = 25,
    parameter int unsigned CARSEL_BURST   = 47,
    parameter int unsigned ASSERT_BURST   = 47,
    parameter int unsigned DEASSERT_BURST = 22
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] COMMAND,
    input  logic       SEND_PACKET,
    output logic       IR_LED,
    output logic       BUSY,
    output logic       PACKET_DONE
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned HALF    = CLK_FREQ / (2 * CARRIER_FREQ);
    localparam int unsigned MAX_LEN = max2(max2(START_BURST, GAP),
                                           max2(CARSEL_BURST, max2(ASSERT_BURST, DEASSERT_BURST)));
    localparam int unsigned HALF_W  = $clog2(HALF + 1);
    localparam int unsigned SEG_W   = $clog2(MAX_LEN + 1);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_G0, S_CARSEL, S_G1, S_RIGHT, S_G2,
        S_LEFT, S_G3, S_BACK, S_G4, S_FWD, S_G5
    } state_t;

    // Segment counter holds (length - 1); the segment ends at the period
    // end where the counter is already zero.
    function automatic logic [SEG_W-1:0] seg_last(input state_t s, input logic [3:0] c);
        int unsigned len;
        case (s)
            S_START:  len = START_BURST;
            S_CARSEL: len = CARSEL_BURST;
            S_RIGHT:  len = c[0] ? ASSERT_BURST : DEASSERT_BURST;
            S_LEFT:   len = c[1] ? ASSERT_BURST : DEASSERT_BURST;
            S_BACK:   len = c[2] ? ASSERT_BURST : DEASSERT_BURST;
            S_FWD:    len = c[3] ? ASSERT_BURST : DEASSERT_BURST;
            default:  len = GAP;
        endcase
        return SEG_W'(len - 1);
    endfunction

    function automatic logic is_burst(input state_t s);
        return (s == S_START) || (s == S_CARSEL) || (s == S_RIGHT) ||
               (s == S_LEFT)  || (s == S_BACK)   || (s == S_FWD);
    endfunction

    state_t              r_state;
    logic [HALF_W-1:0]   r_half_cnt;
    logic                r_phase;
    logic [SEG_W-1:0]    r_seg_cnt;
    logic [3:0]          r_cmd;
    logic                r_sp_q;
    logic                r_ir_led;
    logic                r_done;

    state_t              w_state_nxt;
    state_t              w_adv_state;
    logic [HALF_W-1:0]   w_half_nxt;
    logic                w_phase_nxt;
    logic [SEG_W-1:0]    w_seg_nxt;
    logic [3:0]          w_cmd_nxt;
    logic                w_done_nxt;
    logic                w_led_nxt;
    logic                w_req;
    logic                w_half_wrap;
    logic                w_period_end;
    logic                w_start;
    logic [3:0]          w_start_cmd;

`ifdef IR_PENDING_EN
    logic                r_pend;
    logic [3:0]          r_hold;
    logic                w_pend_nxt;
    logic [3:0]          w_hold_nxt;
`endif

    assign w_req        = SEND_PACKET & ~r_sp_q;
    assign w_half_wrap  = (r_half_cnt == HALF_LAST);
    assign w_period_end = w_half_wrap & ~r_phase;

    // Successor of the current segment.
    always_comb begin
        w_adv_state = S_IDLE;
        case (r_state)
            S_START:  w_adv_state = S_G0;
            S_G0:     w_adv_state = S_CARSEL;
            S_CARSEL: w_adv_state = S_G1;
            S_G1:     w_adv_state = S_RIGHT;
            S_RIGHT:  w_adv_state = S_G2;
            S_G2:     w_adv_state = S_LEFT;
            S_LEFT:   w_adv_state = S_G3;
            S_G3:     w_adv_state = S_BACK;
            S_BACK:   w_adv_state = S_G4;
            S_G4:     w_adv_state = S_FWD;
            S_FWD:    w_adv_state = S_G5;
            default:  w_adv_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half_cnt;
        w_phase_nxt = r_phase;
        w_seg_nxt   = r_seg_cnt;
        w_cmd_nxt   = r_cmd;
        w_done_nxt  = 1'b0;
`ifdef IR_PENDING_EN
        w_pend_nxt  = r_pend;
        w_hold_nxt  = r_hold;
        w_start     = w_req | r_pend;
        w_start_cmd = w_req ? COMMAND : r_hold;
`else
        w_start     = w_req;
        w_start_cmd = COMMAND;
`endif

        if (r_state == S_IDLE) begin
            if (w_start) begin
                w_state_nxt = S_START;
                w_cmd_nxt   = w_start_cmd;
                w_half_nxt  = '0;
                w_phase_nxt = 1'b1;
                w_seg_nxt   = seg_last(S_START, w_start_cmd);
`ifdef IR_PENDING_EN
                w_pend_nxt  = 1'b0;
`endif
            end
        end else begin
`ifdef IR_PENDING_EN
            if (w_req) begin
                w_pend_nxt = 1'b1;
                w_hold_nxt = COMMAND;
            end
`endif
            if (w_half_wrap) begin
                w_half_nxt  = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_half_nxt  = r_half_cnt + HALF_W'(1);
            end

            if (w_period_end) begin
                if (r_seg_cnt == '0) begin
                    w_state_nxt = w_adv_state;
                    w_seg_nxt   = seg_last(w_adv_state, r_cmd);
                    w_done_nxt  = (r_state == S_G5);
                end else begin
                    w_seg_nxt   = r_seg_cnt - SEG_W'(1);
                end
            end
        end

        // Register the LED value for the coming cycle so IR_LED is a flop
        // yet still lines up with the phase of the cycle it is shown in.
        w_led_nxt = is_burst(w_state_nxt) & w_phase_nxt;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
            r_seg_cnt  <= '0;
            r_cmd      <= '0;
            r_sp_q     <= 1'b0;
            r_ir_led   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_half_cnt <= w_half_nxt;
            r_phase    <= w_phase_nxt;
            r_seg_cnt  <= w_seg_nxt;
            r_cmd      <= w_cmd_nxt;
            r_sp_q     <= SEND_PACKET;
            r_ir_led   <= w_led_nxt;
            r_done     <= w_done_nxt;
        end
    end

`ifdef IR_PENDING_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pend <= 1'b0;
            r_hold <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_hold <= w_hold_nxt;
        end
    end
`endif

    assign IR_LED      = r_ir_led;
    assign BUSY        = (r_state != S_IDLE);
    assign PACKET_DONE = r_done;

endmodule

// File: tb/tb_ir_packet_transmitter.sv
module tb_ir_packet_transmitter;

    // Small configuration: HALF=5, period 10 clocks.
    localparam int HALFB  = 5;
    localparam int PER    = 2 * HALFB;
    localparam int L_ST   = 4;
    localparam int L_GAP  = 2;
    localparam int L_CS   = 3;
    localparam int L_AS   = 3;
    localparam int L_DE   = 1;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] COMMAND = 4'b0000;
    logic       SEND_PACKET = 1'b0;
    logic       IR_LED;
    logic       BUSY;
    logic       PACKET_DONE;

    int total = 0;
    int bad   = 0;

    ir_packet_transmitter #(
        .CLK_FREQ(1000),
        .CARRIER_FREQ(100),
        .START_BURST(L_ST),
        .GAP(L_GAP),
        .CARSEL_BURST(L_CS),
        .ASSERT_BURST(L_AS),
        .DEASSERT_BURST(L_DE)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .COMMAND(COMMAND),
        .SEND_PACKET(SEND_PACKET),
        .IR_LED(IR_LED),
        .BUSY(BUSY),
        .PACKET_DONE(PACKET_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] cmd;
        int         chg_at;
        logic [3:0] chg_cmd;
        int         busy;
        int         rises;
        int         highs;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int seg_len(input logic [3:0] c, input int i);
        case (i)
            0:  return L_ST;
            2:  return L_CS;
            4:  return c[0] ? L_AS : L_DE;
            6:  return c[1] ? L_AS : L_DE;
            8:  return c[2] ? L_AS : L_DE;
            10: return c[3] ? L_AS : L_DE;
            default: return L_GAP;
        endcase
    endfunction

    // Expected IR_LED at cycle t counted from the first BUSY cycle.
    function automatic logic exp_led(input logic [3:0] c, input int t);
        int r;
        r = t;
        for (int i = 0; i < 12; i++) begin
            if (r < seg_len(c, i) * PER)
                return ((i % 2) == 0) && ((r % PER) < HALFB);
            r -= seg_len(c, i) * PER;
        end
        return 1'b0;
    endfunction

    // Starts in the first BUSY cycle, ends in the PACKET_DONE cycle.
    task automatic observe(input logic [3:0] cmd, input int chg_at, input logic [3:0] chg_cmd,
                           input int busy_exp, input int rises_exp, input int highs_exp);
        int n, rises, highs, wav_bad, early_done;
        logic prev;
        n = 0; rises = 0; highs = 0; wav_bad = 0; early_done = 0; prev = 1'b0;
        while (BUSY && n < 1000) begin
            if (n == chg_at) COMMAND = chg_cmd;
            if (IR_LED !== exp_led(cmd, n)) wav_bad++;
            if (IR_LED && !prev) rises++;
            if (IR_LED) highs++;
            if (PACKET_DONE) early_done++;
            prev = IR_LED;
            n++;
            step();
        end
        chk("busy_len", n, busy_exp);
        chk("led_rises", rises, rises_exp);
        chk("led_high_cycles", highs, highs_exp);
        chk("led_waveform_errs", wav_bad, 0);
        chk("done_while_busy", early_done, 0);
        chk("done_pulse", int'(PACKET_DONE), 1);
        chk("led_idle", int'(IR_LED), 0);
    endtask

    task automatic run_packet(input logic [3:0] cmd, input int chg_at, input logic [3:0] chg_cmd,
                              input int busy_exp, input int rises_exp, input int highs_exp);
        COMMAND = cmd;
        SEND_PACKET = 1'b1;
        step();
        chk("latency_busy", int'(BUSY), 1);
        chk("latency_led", int'(IR_LED), 1);
        SEND_PACKET = 1'b0;
        observe(cmd, chg_at, chg_cmd, busy_exp, rises_exp, highs_exp);
    endtask

    initial begin
        int cnt, starts;
        logic pb;

        vecs[0] = '{4'b1001, -1, 4'b0000, 270, 15, 75};
        vecs[1] = '{4'b0000, -1, 4'b0000, 230, 11, 55};
        vecs[2] = '{4'b1111, 50, 4'b0000, 310, 19, 95};
        vecs[3] = '{4'b0010, -1, 4'b0000, 250, 13, 65};
        vecs[4] = '{4'b0101, -1, 4'b0000, 270, 15, 75};
        vecs[5] = '{4'b1000, -1, 4'b0000, 250, 13, 65};

        // Reset state
        step();
        chk("rst_led", int'(IR_LED), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(PACKET_DONE), 0);
        step();
        RESET = 1'b1;
        repeat (3) step();
        chk("idle_busy", int'(BUSY), 0);

        // Table-driven packets
        for (int i = 0; i < 6; i++) begin
            run_packet(vecs[i].cmd, vecs[i].chg_at, vecs[i].chg_cmd,
                       vecs[i].busy, vecs[i].rises, vecs[i].highs);
            step();
            chk("done_clear", int'(PACKET_DONE), 0);
            chk("busy_after", int'(BUSY), 0);
            repeat (3) step();
        end

        // Back-to-back: request in the PACKET_DONE cycle is accepted
        run_packet(4'b0000, -1, 4'b0000, 230, 11, 55);
        run_packet(4'b1111, -1, 4'b0000, 310, 19, 95);
        step();
        repeat (3) step();

        // SEND_PACKET held high: one packet only
        COMMAND = 4'b1001;
        SEND_PACKET = 1'b1;
        starts = 0; cnt = 0; pb = 1'b0;
        for (int k = 0; k < 500; k++) begin
            step();
            if (BUSY && !pb) starts++;
            if (BUSY) cnt++;
            pb = BUSY;
        end
        chk("hold_starts", starts, 1);
        chk("hold_busy_cycles", cnt, 270);
        SEND_PACKET = 1'b0;
        step();
        chk("hold_low_idle", int'(BUSY), 0);
        run_packet(4'b1001, -1, 4'b0000, 270, 15, 75);
        step();
        repeat (3) step();

        // Reset mid-packet
        COMMAND = 4'b1001;
        SEND_PACKET = 1'b1;
        step();
        SEND_PACKET = 1'b0;
        repeat (111) step();
        chk("pre_rst_led", int'(IR_LED), 1);
        chk("pre_rst_busy", int'(BUSY), 1);
        RESET = 1'b0;
        #1;
        chk("async_rst_led", int'(IR_LED), 0);
        chk("async_rst_busy", int'(BUSY), 0);
        step();
        step();
        RESET = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (BUSY || IR_LED) cnt++;
        end
        chk("post_rst_quiet", cnt, 0);
        run_packet(4'b0000, -1, 4'b0000, 230, 11, 55);
        step();
        repeat (3) step();

        // Second request while busy
        COMMAND = 4'b1001;
        SEND_PACKET = 1'b1;
        step();
        SEND_PACKET = 1'b0;
        repeat (100) step();
        COMMAND = 4'b0010;
        SEND_PACKET = 1'b1;
        step();
        SEND_PACKET = 1'b0;
        COMMAND = 4'b1111;
        cnt = 101;
        while (!PACKET_DONE && cnt < 1000) begin
            step();
            cnt++;
        end
        chk("first_pkt_len", cnt, 270);
        chk("first_pkt_done", int'(PACKET_DONE), 1);
        chk("first_pkt_busy_low", int'(BUSY), 0);
        step();
`ifdef IR_PENDING_EN
        chk("pending_start", int'(BUSY), 1);
        chk("pending_led", int'(IR_LED), 1);
        observe(4'b0010, -1, 4'b0000, 250, 13, 65);
        step();
`else
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            if (BUSY) cnt++;
            step();
        end
        chk("dropped_request", cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ir_packet_transmitter.md
Name: ir_packet_transmitter

Overview:
- Downstream stage of the IR command front end. Consumes the registered 4-bit COMMAND and the periodic SEND_PACKET strobe from the 10 Hz counter, and drives IR_LED.
- Each request produces one remote-control car packet: Start, CarSelect, Right, Left, Backward and Forward bursts, each followed by a gap. Bursts are modulated on a parameterised carrier.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- CARRIER_FREQ, 36000, carrier frequency in Hz. HALF = CLK_FREQ/(2*CARRIER_FREQ), integer division; HALF must be at least 1.
- START_BURST, 191, Start burst length in carrier periods.
- GAP, 25, length of every gap in carrier periods.
- CARSEL_BURST, 47, CarSelect burst length in carrier periods.
- ASSERT_BURST, 47, burst length in carrier periods for a command bit = 1.
- DEASSERT_BURST, 22, burst length in carrier periods for a command bit = 0.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- COMMAND  in  4  [0]=Right, [1]=Left, [2]=Backward, [3]=Forward.
- SEND_PACKET  in  1  packet request; a rising edge starts a packet.
- IR_LED  out  1  modulated IR output, registered.
- BUSY  out  1  high while a packet is in progress.
- PACKET_DONE  out  1  one-cycle pulse when the final gap completes.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, IR_LED=0, BUSY=0, PACKET_DONE=0, all counters 0, edge-detect register 0. Reset mid-packet aborts the packet immediately. IR_LED falls without waiting for a clock.
- Edge detect: sp_q <= SEND_PACKET each cycle. The request is SEND_PACKET & ~sp_q. A level held high starts only one packet.
- IDLE: on a request, latch COMMAND into cmd_r and clear the carrier counters. Next state is START, with BUSY=1 from the next cycle. Requests seen while BUSY=1 are ignored; see the optional feature for the exception.
- Carrier generator: active only while BUSY.
  - half_cnt counts 0..HALF-1. At HALF-1 it wraps and toggles phase.
  - phase is 1 for the first HALF cycles of each period.
  - A period ends when the cycle has half_cnt=HALF-1 and phase=0.
- Segment counter: loaded with the segment length on entry to each state. It decrements at each period end. When the count reaches the last period, the FSM advances at that period end.
- Segments are therefore aligned to carrier period boundaries. Every segment lasts exactly length*2*HALF clocks.
- State sequence: START(START_BURST), G0, CARSEL(CARSEL_BURST), G1, RIGHT, G2, LEFT, G3, BACK, G4, FWD, G5 -> IDLE. Every Gn lasts GAP periods.
- Command-bit bursts: each lasts ASSERT_BURST periods if its latched cmd_r bit is 1, otherwise DEASSERT_BURST periods.
- IR_LED is registered and equals phase in burst states; it is 0 in gap states and IDLE.
- Latency: the request is detected in cycle N. IR_LED=1 from cycle N+1.
- Completion: on leaving G5, PACKET_DONE=1 for one cycle, BUSY=0 in that same cycle, and state is IDLE.
- A new request detected in that same cycle is accepted, so back-to-back packets have zero idle cycles.
- COMMAND changes during a packet have no effect on the packet in progress; only cmd_r is used.
- Width rules: counter widths are $clog2 of the maximum value plus 1. There is no arithmetic overflow for any legal parameter set.

Optional Feature:
- Macro IR_PENDING_EN.
- When defined: a request detected while BUSY sets a pending flag, and COMMAND is re-sampled into a holding register at that moment; a later request overwrites it. On completion, a packet with the held command starts in the next cycle and the flag clears. Reset clears both the flag and the holding register.
- When undefined: requests while BUSY are dropped, and the flag and holding register are not synthesised.

Test Plan (CLK_FREQ=1000, CARRIER_FREQ=100 so HALF=5; START=4, GAP=2, CARSEL=3, ASSERT=3, DEASSERT=1):
- COMMAND=4'b1001, one SEND_PACKET pulse:
  - Start burst shows 4 IR_LED rising edges, each high 5 and low 5 cycles.
  - Segment lengths are 4,2,3,2,3,2,1,2,1,2,3,2 periods.
  - Total BUSY duration is 270 cycles, followed by one PACKET_DONE pulse.
- COMMAND=4'b0000 -> BUSY lasts 230 cycles. IR_LED=0 for exactly 20 cycles during each gap.
- SEND_PACKET held high for 500 cycles -> exactly one packet. A second packet starts only after SEND_PACKET goes low and high again.
- COMMAND changed from 4'b1111 to 4'b0000 at cycle 50 of a packet -> the packet is still 310 cycles, with all bits asserted.
- RESET asserted at cycle 100 of a packet -> IR_LED=0 and BUSY=0 immediately. After release, no packet occurs until the next rising edge.
- IR_PENDING_EN defined, second request at cycle 100 with COMMAND=4'b0010 -> the second packet starts the cycle after PACKET_DONE and lasts 250 cycles. With the macro undefined, the second request is dropped.
